// File: rtl/dmem_req_ctrl.sv
// Data-memory request initiator: issues d_rd/d_wr for one pipeline request at a time,
// retries on miss with a fixed backoff gap and reports completion, timeout and segfault.
module dmem_req_ctrl #(
  parameter int unsigned MAX_RETRY = 15,
  parameter int unsigned RETRY_GAP = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wr_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wr_data_i,
  input  logic [2:0]  req_trd_i,
  input  logic        flush_i,
  input  logic [2:0]  flush_trd_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic [2:0]  rsp_trd_o,
  output logic        rsp_fault_o,
  output logic        rsp_timeout_o,
  output logic [31:0] d_addr_o,
  output logic [31:0] d_wr_data_o,
  output logic        d_rd_o,
  output logic        d_wr_o,
  output logic [2:0]  d_trd_o,
  input  logic [31:0] d_rd_data_i,
  input  logic        d_miss_i,
  input  logic        d_segfault_i,
  output logic        seg_exp_o,
  output logic [2:0]  seg_trd_o,
  output logic [31:0] seg_addr_o
);

  localparam int unsigned DW    = 32;
  localparam int unsigned TW    = 3;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned GAP_W = 4;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_BACKOFF = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             abort_q, abort_d;
  logic             wr_q, wr_d;
  logic [DW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    data_q, data_d;
  logic [TW-1:0]    trd_q, trd_d;

  logic             req_ready_q, req_ready_d;
  logic             d_rd_q, d_rd_d, d_wr_q, d_wr_d;
  logic [DW-1:0]    d_addr_q, d_addr_d, d_wr_data_q, d_wr_data_d;
  logic [TW-1:0]    d_trd_q, d_trd_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]    rsp_data_q, rsp_data_d;
  logic [TW-1:0]    rsp_trd_q, rsp_trd_d;
  logic             rsp_fault_q, rsp_fault_d, rsp_timeout_q, rsp_timeout_d;
  logic             seg_exp_q, seg_exp_d;
  logic [TW-1:0]    seg_trd_q, seg_trd_d;
  logic [DW-1:0]    seg_addr_q, seg_addr_d;

  logic flush_hit, abort_now, fin, fin_fault, fin_tout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      gap_q         <= '0;
      abort_q       <= 1'b0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      trd_q         <= '0;
      req_ready_q   <= 1'b1;
      d_rd_q        <= 1'b0;
      d_wr_q        <= 1'b0;
      d_addr_q      <= '0;
      d_wr_data_q   <= '0;
      d_trd_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_trd_q     <= '0;
      rsp_fault_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      seg_exp_q     <= 1'b0;
      seg_trd_q     <= '0;
      seg_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
      abort_q       <= abort_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      trd_q         <= trd_d;
      req_ready_q   <= req_ready_d;
      d_rd_q        <= d_rd_d;
      d_wr_q        <= d_wr_d;
      d_addr_q      <= d_addr_d;
      d_wr_data_q   <= d_wr_data_d;
      d_trd_q       <= d_trd_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_trd_q     <= rsp_trd_d;
      rsp_fault_q   <= rsp_fault_d;
      rsp_timeout_q <= rsp_timeout_d;
      seg_exp_q     <= seg_exp_d;
      seg_trd_q     <= seg_trd_d;
      seg_addr_q    <= seg_addr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    gap_d         = gap_q;
    abort_d       = abort_q;
    wr_d          = wr_q;
    addr_d        = addr_q;
    data_d        = data_q;
    trd_d         = trd_q;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = '0;
    rsp_trd_d     = '0;
    rsp_fault_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    seg_exp_d     = 1'b0;
    seg_trd_d     = '0;
    seg_addr_d    = '0;
    fin           = 1'b0;
    fin_fault     = 1'b0;
    fin_tout      = 1'b0;
    flush_hit     = flush_i && (flush_trd_i == trd_q);
    abort_now     = abort_q || flush_hit;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          wr_d    = req_wr_i;
          addr_d  = req_addr_i;
          data_d  = req_wr_data_i;
          trd_d   = req_trd_i;
          cnt_d   = '0;
          abort_d = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        abort_d = abort_now;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        abort_d = abort_now;
        if (d_segfault_i) begin
          fin       = 1'b1;
          fin_fault = 1'b1;
        end else if (d_miss_i && (cnt_q < CNT_W'(MAX_RETRY))) begin
          cnt_d   = cnt_q + CNT_W'(1);
          gap_d   = '0;
          state_d = S_BACKOFF;
        end else begin
          fin      = 1'b1;
          fin_tout = d_miss_i;
        end
      end
      S_BACKOFF: begin
        // An owner flush while idle on the bus drops the request outright
        if (flush_hit) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          abort_d = 1'b0;
        end else if (gap_q == GAP_W'(RETRY_GAP - 1)) begin
          state_d = S_ISSUE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fin) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      abort_d = 1'b0;
      if (!abort_now) begin
        rsp_valid_d   = 1'b1;
        rsp_trd_d     = trd_q;
        rsp_fault_d   = fin_fault;
        rsp_timeout_d = fin_tout;
        rsp_data_d    = (!fin_fault && !fin_tout && !wr_q) ? d_rd_data_i : '0;
        seg_exp_d     = fin_fault;
        seg_trd_d     = fin_fault ? trd_q : '0;
        seg_addr_d    = fin_fault ? addr_q : '0;
      end
    end

    // Bus command registers follow the state being entered
    req_ready_d = (state_d == S_IDLE);
    d_rd_d      = (state_d == S_ISSUE) && !wr_d;
    d_wr_d      = (state_d == S_ISSUE) && wr_d;
    d_addr_d    = (state_d == S_ISSUE) ? addr_d : d_addr_q;
    d_wr_data_d = (state_d == S_ISSUE) ? data_d : d_wr_data_q;
    d_trd_d     = (state_d == S_ISSUE) ? trd_d  : d_trd_q;
  end

  assign req_ready_o   = req_ready_q;
  assign d_rd_o        = d_rd_q;
  assign d_wr_o        = d_wr_q;
  assign d_addr_o      = d_addr_q;
  assign d_wr_data_o   = d_wr_data_q;
  assign d_trd_o       = d_trd_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_trd_o     = rsp_trd_q;
  assign rsp_fault_o   = rsp_fault_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign seg_exp_o     = seg_exp_q;
  assign seg_trd_o     = seg_trd_q;
  assign seg_addr_o    = seg_addr_q;

endmodule
